// File: rtl/axim_pkg.sv
// axim_pkg: FSM encodings, AXI response codes and response helper for the axim bridge.
package axim_pkg;
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RR, DONE} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic resp_err(input logic [1:0] r);
    return r != RESP_OKAY;
  endfunction
endpackage

// File: rtl/axim_if.sv
// axim_if: LSU request handshake plus the five AXI4-Lite channels as seen by the bridge.
interface axim_if #(parameter int AW = 32, parameter int DW = 32);
  logic hs_ls4axim_val, hs_axim4ls_rdy;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_wdat;
  logic [3:0] i_wen;
  logic i_ren;
  logic [DW-1:0] o_rdat;
  logic o_err;
  logic [AW-1:0] o_awaddr;
  logic [2:0] o_awprot;
  logic o_awvalid, i_awready;
  logic [DW-1:0] o_wdata;
  logic [3:0] o_wstrb;
  logic o_wvalid, i_wready;
  logic [1:0] i_bresp;
  logic i_bvalid, o_bready;
  logic [AW-1:0] o_araddr;
  logic [2:0] o_arprot;
  logic o_arvalid, i_arready;
  logic [DW-1:0] i_rdata;
  logic [1:0] i_rresp;
  logic i_rvalid, o_rready;
  modport mst (
    input hs_ls4axim_val, i_adr, i_wdat, i_wen, i_ren, i_awready, i_wready, i_bresp, i_bvalid,
          i_arready, i_rdata, i_rresp, i_rvalid,
    output hs_axim4ls_rdy, o_rdat, o_err, o_awaddr, o_awprot, o_awvalid, o_wdata, o_wstrb,
           o_wvalid, o_bready, o_araddr, o_arprot, o_arvalid, o_rready
  );
  modport slv (
    output hs_ls4axim_val, i_adr, i_wdat, i_wen, i_ren, i_awready, i_wready, i_bresp, i_bvalid,
           i_arready, i_rdata, i_rresp, i_rvalid,
    input hs_axim4ls_rdy, o_rdat, o_err, o_awaddr, o_awprot, o_awvalid, o_wdata, o_wstrb,
          o_wvalid, o_bready, o_araddr, o_arprot, o_arvalid, o_rready
  );
endinterface

// File: rtl/axim.sv
// axim: single-outstanding LSU-to-AXI4-Lite master; every output comes straight from a flop.
module axim #(parameter int AW = 32, parameter int DW = 32) (
  input logic clk,
  input logic rst_n,
  axim_if.mst bus
);
  import axim_pkg::*;
  state_t state, state_n;
  logic aw_done, w_done, aw_ok, w_ok, wr_go;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [3:0] wen;
  assign aw_ok = aw_done | (bus.o_awvalid & bus.i_awready);
  assign w_ok = w_done | (bus.o_wvalid & bus.i_wready);
  assign wr_go = state == IDLE && state_n == WR;
  assign bus.o_awaddr = adr;
  assign bus.o_araddr = adr;
  assign bus.o_wdata = wdat;
  assign bus.o_wstrb = wen;
  assign bus.o_awprot = 3'b000;
  assign bus.o_arprot = 3'b000;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.hs_ls4axim_val) state_n = |bus.i_wen ? WR : bus.i_ren ? RA : DONE;
      WR: if (aw_ok && w_ok) state_n = WB;
      WB: if (bus.i_bvalid) state_n = DONE;
      RA: if (bus.i_arready) state_n = RR;
      RR: if (bus.i_rvalid) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // Registered outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      adr <= '0;
      wdat <= '0;
      wen <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      bus.o_awvalid <= 1'b0;
      bus.o_wvalid <= 1'b0;
      bus.o_bready <= 1'b0;
      bus.o_arvalid <= 1'b0;
      bus.o_rready <= 1'b0;
      bus.hs_axim4ls_rdy <= 1'b0;
      bus.o_err <= 1'b0;
      bus.o_rdat <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.hs_ls4axim_val) begin
        adr <= bus.i_adr;
        wdat <= bus.i_wdat;
        wen <= bus.i_wen;
      end
      aw_done <= state == WR && aw_ok;
      w_done <= state == WR && w_ok;
      bus.o_awvalid <= wr_go | (bus.o_awvalid & ~bus.i_awready);
      bus.o_wvalid <= wr_go | (bus.o_wvalid & ~bus.i_wready);
      bus.o_bready <= state_n == WB;
      bus.o_arvalid <= state_n == RA;
      bus.o_rready <= state_n == RR;
      bus.hs_axim4ls_rdy <= state_n == DONE;
      bus.o_err <= state_n == DONE && (state == WB ? resp_err(bus.i_bresp) : state == RR && resp_err(bus.i_rresp));
      if (state == RR && bus.i_rvalid) bus.o_rdat <= bus.i_rdata;
    end
endmodule

// File: tb/tb_axim.sv
// tb_axim: table-driven directed checks of axim against a latency-programmable AXI4-Lite slave.
module tb_axim;
  import axim_pkg::*;
  typedef struct {
    string nm;
    logic [3:0] wen;
    logic ren;
    logic [31:0] adr, wdat, rdata;
    logic [1:0] bresp, rresp;
    int aw_lat, w_lat, b_lat, ar_lat, r_lat;
    int e_cyc;
    logic [31:0] e_rdat;
    logic e_err;
    int e_aw, e_w, e_ar, e_wv;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  int aw_lat, w_lat, b_lat, ar_lat, r_lat;
  int aw_age, w_age, b_age, ar_age, r_age;
  vec_t vt[8];
  vec_t vn;
  axim_if #(.AW(32), .DW(32)) bus();
  axim #(.AW(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic slave_step();
    bus.i_awready = bus.o_awvalid && aw_age >= aw_lat;
    aw_age = bus.o_awvalid ? aw_age + 1 : 0;
    bus.i_wready = bus.o_wvalid && w_age >= w_lat;
    w_age = bus.o_wvalid ? w_age + 1 : 0;
    bus.i_bvalid = bus.o_bready && b_age >= b_lat;
    b_age = bus.o_bready ? b_age + 1 : 0;
    bus.i_arready = bus.o_arvalid && ar_age >= ar_lat;
    ar_age = bus.o_arvalid ? ar_age + 1 : 0;
    bus.i_rvalid = bus.o_rready && r_age >= r_lat;
    r_age = bus.o_rready ? r_age + 1 : 0;
  endtask
  task automatic run(input vec_t v);
    int got, aw_n, w_n, ar_n, wv_n, bad;
    logic [31:0] rdat;
    logic err;
    got = -1; aw_n = 0; w_n = 0; ar_n = 0; wv_n = 0; bad = 0; rdat = 'x; err = 1'bx;
    aw_lat = v.aw_lat; w_lat = v.w_lat; b_lat = v.b_lat; ar_lat = v.ar_lat; r_lat = v.r_lat;
    bus.i_bresp = v.bresp; bus.i_rresp = v.rresp; bus.i_rdata = v.rdata;
    bus.hs_ls4axim_val = 1'b1; bus.i_adr = v.adr; bus.i_wdat = v.wdat; bus.i_wen = v.wen; bus.i_ren = v.ren;
    for (int c = 1; c <= 40 && got < 0; c++) begin
      @(negedge clk);
      bus.hs_ls4axim_val = 1'b0;
      bus.i_adr = ~v.adr; bus.i_wdat = ~v.wdat; bus.i_wen = ~v.wen; bus.i_ren = ~v.ren;
      slave_step();
      aw_n += int'(bus.o_awvalid && bus.i_awready);
      w_n += int'(bus.o_wvalid && bus.i_wready);
      ar_n += int'(bus.o_arvalid && bus.i_arready);
      wv_n += int'(bus.o_wvalid);
      bad += int'(bus.o_awvalid && (bus.o_awaddr !== v.adr || bus.o_awprot !== 3'b000));
      bad += int'(bus.o_wvalid && (bus.o_wdata !== v.wdat || bus.o_wstrb !== v.wen));
      bad += int'(bus.o_arvalid && (bus.o_araddr !== v.adr || bus.o_arprot !== 3'b000));
      if (bus.hs_axim4ls_rdy) begin
        got = c; rdat = bus.o_rdat; err = bus.o_err;
      end
    end
    chk({v.nm, ".rdy_cycle"}, got, v.e_cyc);
    chk({v.nm, ".rdat"}, rdat, v.e_rdat);
    chk({v.nm, ".err"}, {31'd0, err}, {31'd0, v.e_err});
    chk({v.nm, ".aw_hs"}, aw_n, v.e_aw);
    chk({v.nm, ".w_hs"}, w_n, v.e_w);
    chk({v.nm, ".ar_hs"}, ar_n, v.e_ar);
    chk({v.nm, ".wvalid_cycles"}, wv_n, v.e_wv);
    chk({v.nm, ".payload_unstable"}, bad, 0);
    @(negedge clk);
    slave_step();
    chk({v.nm, ".rdy_pulse"}, {31'd0, bus.hs_axim4ls_rdy}, 32'd0);
    chk({v.nm, ".err_clear"}, {31'd0, bus.o_err}, 32'd0);
  endtask
  task automatic chk_quiet(input string nm, input logic [31:0] e_rdat);
    chk({nm, ".valids"}, {28'd0, bus.o_awvalid, bus.o_wvalid, bus.o_arvalid, 1'b0}, 32'd0);
    chk({nm, ".readys"}, {30'd0, bus.o_bready, bus.o_rready}, 32'd0);
    chk({nm, ".rdy_err"}, {30'd0, bus.hs_axim4ls_rdy, bus.o_err}, 32'd0);
    chk({nm, ".rdat"}, bus.o_rdat, e_rdat);
  endtask
  initial begin
    vt[0] = '{"rd_okay", 4'h0, 1'b1, 32'h0001_0004, 32'h0, 32'hDEAD_BEEF, RESP_OKAY, RESP_OKAY, 0, 0, 0, 0, 0, 3, 32'hDEAD_BEEF, 1'b0, 0, 0, 1, 0};
    vt[1] = '{"wr_wlag", 4'b0011, 1'b0, 32'h0000_0100, 32'h1234_5678, 32'h0, RESP_OKAY, RESP_OKAY, 0, 2, 0, 0, 0, 5, 32'hDEAD_BEEF, 1'b0, 1, 1, 0, 3};
    vt[2] = '{"wr_and_rd", 4'hF, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 32'h1111_1111, RESP_OKAY, RESP_OKAY, 0, 0, 0, 0, 0, 3, 32'hDEAD_BEEF, 1'b0, 1, 1, 0, 1};
    vt[3] = '{"rd_slverr", 4'h0, 1'b1, 32'h0000_0033, 32'h0, 32'hCAFE_0001, RESP_OKAY, RESP_SLVERR, 0, 0, 0, 0, 0, 3, 32'hCAFE_0001, 1'b1, 0, 0, 1, 0};
    vt[4] = '{"rd_wait", 4'h0, 1'b1, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, RESP_OKAY, RESP_OKAY, 0, 0, 0, 2, 1, 6, 32'h0BAD_F00D, 1'b0, 0, 0, 1, 0};
    vt[5] = '{"noop", 4'h0, 1'b0, 32'h0000_0055, 32'h99, 32'h7777_7777, RESP_OKAY, RESP_OKAY, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 1'b0, 0, 0, 0, 0};
    vt[6] = '{"wr_decerr", 4'b1000, 1'b0, 32'h0000_0066, 32'hFEED_FACE, 32'h0, RESP_DECERR, RESP_OKAY, 2, 0, 1, 0, 0, 6, 32'h0BAD_F00D, 1'b1, 1, 1, 0, 1};
    vt[7] = '{"wr_same", 4'b0110, 1'b0, 32'h0000_0077, 32'h0F0F_0F0F, 32'h0, RESP_OKAY, RESP_OKAY, 1, 1, 0, 0, 0, 4, 32'h0BAD_F00D, 1'b0, 1, 1, 0, 2};
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
    aw_age = 0; w_age = 0; b_age = 0; ar_age = 0; r_age = 0;
    bus.hs_ls4axim_val = 1'b0; bus.i_adr = '0; bus.i_wdat = '0; bus.i_wen = '0; bus.i_ren = 1'b0;
    bus.i_awready = 1'b0; bus.i_wready = 1'b0; bus.i_bresp = '0; bus.i_bvalid = 1'b0;
    bus.i_arready = 1'b0; bus.i_rdata = '0; bus.i_rresp = '0; bus.i_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset", 32'h0);
    chk("reset.addr", bus.o_awaddr | bus.o_araddr | bus.o_wdata | {28'd0, bus.o_wstrb}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    slave_step();
    chk_quiet("idle", 32'h0);
    for (int i = 0; i < 8; i++) run(vt[i]);
    bus.hs_ls4axim_val = 1'b1; bus.i_wen = 4'h0; bus.i_ren = 1'b0;
    @(negedge clk);
    slave_step();
    chk("done_busy.rdy", {31'd0, bus.hs_axim4ls_rdy}, 32'd1);
    bus.i_ren = 1'b1; bus.i_adr = 32'h0000_0099;
    @(negedge clk);
    slave_step();
    bus.hs_ls4axim_val = 1'b0;
    chk("done_busy.ignored", {30'd0, bus.hs_axim4ls_rdy, bus.o_arvalid}, 32'd0);
    @(negedge clk);
    slave_step();
    chk("done_busy.still_idle", {31'd0, bus.o_arvalid}, 32'd0);
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 10;
    bus.i_rdata = 32'h5555_AAAA; bus.i_rresp = RESP_OKAY;
    bus.hs_ls4axim_val = 1'b1; bus.i_adr = 32'h0000_0088; bus.i_wen = 4'h0; bus.i_ren = 1'b1;
    @(negedge clk);
    bus.hs_ls4axim_val = 1'b0;
    slave_step();
    chk("rst_mid.ar_hs", {31'd0, bus.o_arvalid && bus.i_arready}, 32'd1);
    @(negedge clk);
    slave_step();
    chk("rst_mid.in_rr", {31'd0, bus.o_rready}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_quiet("rst_mid.async", 32'h0);
    chk("rst_mid.araddr", bus.o_araddr, 32'h0);
    @(negedge clk);
    slave_step();
    rst_n = 1'b1;
    @(negedge clk);
    slave_step();
    chk_quiet("rst_mid.idle", 32'h0);
    vn = '{"post_rst_noop", 4'h0, 1'b0, 32'h0000_00AB, 32'h0, 32'h0, RESP_OKAY, RESP_OKAY, 0, 0, 0, 0, 0, 1, 32'h0, 1'b0, 0, 0, 0, 0};
    run(vn);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axim.md
AXIM -- requirements
Module: axim

Interface
REQ-001 Parameter AW = 32: address width, and the width of i_adr, o_awaddr and o_araddr.
REQ-002 Parameter DW = 32: data width; DW = 32 is the only supported value.
REQ-003 Port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port hs_ls4axim_val, input, 1: request valid from the LSU.
REQ-006 Port hs_axim4ls_rdy, output, 1: request complete; a one-cycle pulse.
REQ-007 Port i_adr, input, AW: byte address of the request.
REQ-008 Port i_wdat, input, 32: write data.
REQ-009 Port i_wen, input, 4: byte write enables.
REQ-010 Port i_ren, input, 1: read enable.
REQ-011 Port o_rdat, output, 32: read data.
REQ-012 Port o_err, output, 1: error flag, valid together with hs_axim4ls_rdy.
REQ-013 AXI4-Lite write-address channel ports: o_awaddr (AW, out), o_awprot (3, out), o_awvalid (out), i_awready (in).
REQ-014 AXI4-Lite write-data channel ports: o_wdata (32, out), o_wstrb (4, out), o_wvalid (out), i_wready (in).
REQ-015 AXI4-Lite write-response channel ports: i_bresp (2, in), i_bvalid (in), o_bready (out).
REQ-016 AXI4-Lite read-address channel ports: o_araddr (AW, out), o_arprot (3, out), o_arvalid (out), i_arready (in).
REQ-017 AXI4-Lite read-data channel ports: i_rdata (32, in), i_rresp (2, in), i_rvalid (in), o_rready (out).

Function
REQ-018 FSM states SHALL be IDLE, WR, WB, RA, RR and DONE; every output SHALL be driven from registers, with no combinational path from any input to any output.
REQ-019 In IDLE, hs_ls4axim_val=1 SHALL latch adr/wdat/wen/ren; wen!=0 goes to WR, else ren=1 goes to RA, else (no-op) goes to DONE.
REQ-020 When wen!=0, ren SHALL be ignored: a request with both set is performed as a write only.
REQ-021 WR SHALL assert o_awvalid and o_wvalid together and drop each independently on its own handshake; the FSM SHALL move to WB when both handshakes are done, in any order or in the same cycle.
REQ-022 WB SHALL hold o_bready=1 and move to DONE on i_bvalid.
REQ-023 RA SHALL hold o_arvalid until i_arready, then move to RR.
REQ-024 RR SHALL hold o_rready=1; on i_rvalid it SHALL register i_rdata into o_rdat and move to DONE.
REQ-025 DONE SHALL assert hs_axim4ls_rdy for exactly one cycle, then return to IDLE; no new request is accepted in DONE.
REQ-026 o_err SHALL be 1 in DONE when the latched bresp/rresp != 2'b00, and 0 for a no-op.
REQ-027 o_rdat SHALL hold its value until the next read completes; it is unchanged by writes and no-ops.
REQ-028 o_awprot and o_arprot SHALL be tied to 3'b000; the address SHALL pass through unmodified (no alignment).
REQ-029 Any VALID, once asserted, SHALL NOT drop before its handshake, and the address/data/strobe it carries SHALL NOT change while it is high.
REQ-030 Latency with zero-wait slaves SHALL be: read val at cycle 0 -> arvalid at 1 -> rvalid at 2 -> rdy at 3; write -> rdy at 3; no-op -> rdy at 1.
REQ-031 Request inputs SHALL be sampled in IDLE only; changes to them mid-transaction SHALL be ignored.
REQ-032 A response VALID arriving before the matching address handshake SHALL be ignored; the slave is responsible for ordering.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE and all VALID/READY, hs_axim4ls_rdy and o_err outputs SHALL be 0, o_rdat SHALL be 0, and the latched address/data/strobe outputs SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction immediately; recovery of the slave is a system-level concern.

Structure
REQ-035 FSM state encodings and the AXI response codes (OKAY=00, SLVERR=10, DECERR=11) SHALL live in the shared define file cirno9_define.v.
REQ-036 No sub-module is required; the write-channel done flags (aw_done, w_done) SHALL be local registers.

Verification
REQ-037 Bench SHALL cover: zero-wait read of 0x0001_0004, slave returning 0xDEAD_BEEF with OKAY -> rdy at cycle 3, o_rdat=0xDEADBEEF, o_err=0.
REQ-038 Bench SHALL cover: write wen=4'b0011 with wready 2 cycles later than awready -> wvalid held 2 extra cycles with stable wdata and wstrb=0011, rdy one cycle after bvalid.
REQ-039 Bench SHALL cover: wen=4'hF and ren=1 together -> write only, arvalid never asserted.
REQ-040 Bench SHALL cover: read with rresp=2'b10 -> rdy and o_err=1 in the same cycle; o_err=0 on the next OKAY transaction.
REQ-041 Bench SHALL cover: wen=0 and ren=0 -> rdy at cycle 1 with no AXI activity and o_rdat unchanged.
REQ-042 Bench SHALL cover: rst_n pulled low while in RR with arready already seen -> all VALIDs and READYs 0 asynchronously, then IDLE after release.
